// File: rtl/eth_pkg.sv
// Shared definitions for the Ethernet receive / FCS checking path:
// FSM state encoding, MII nibble codes and CRC-32 constants.
package eth_pkg;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        PREAMBLE = 2'd1,
        DATA     = 2'd2,
        DROP     = 2'd3
    } state_t;

    localparam logic [3:0]  PREAMBLE_NIB = 4'h5;
    localparam logic [3:0]  SFD_NIB      = 4'hD;
    localparam logic [31:0] CRC_INIT     = 32'hFFFFFFFF;
    localparam logic [31:0] CRC_RESIDUE  = 32'hDEBB20E3;
    localparam logic [31:0] CRC_POLY     = 32'hEDB88320;

endpackage

// File: rtl/crc32.sv
// Combinational reflected CRC-32 update over WIDTH data bits, LSB first.
// Ports: crc_in (current register), data (new bits), crc_out (next value).
module crc32
    import eth_pkg::*;
#(
    parameter int WIDTH = 4
) (
    input  logic [31:0]      crc_in,
    input  logic [WIDTH-1:0] data,
    output logic [31:0]      crc_out
);

    always_comb begin
        crc_out = crc_in;
        for (int i = 0; i < WIDTH; i++) begin
            if (crc_out[0] ^ data[i]) begin
                crc_out = (crc_out >> 1) ^ CRC_POLY;
            end else begin
                crc_out = crc_out >> 1;
            end
        end
    end

endmodule

// File: rtl/eth_rx_fcs.sv
// MII receive path: preamble/SFD detection, nibble-to-byte packing, FCS
// check and strip. Payload leaves on m_data/m_valid/m_last/m_err, with
// one-cycle frame_ok/frame_bad status at end of frame.
// Inputs: clk, rst_n (async, active low), mii_rxd[3:0], mii_rx_dv, mii_rx_er.
// Outputs: m_data[7:0], m_valid, m_last, m_err, frame_ok, frame_bad.
// Build option: define ETH_RX_MINLEN_CHECK_EN to reject frames < MIN_LEN.
module eth_rx_fcs
    import eth_pkg::*;
#(
    parameter int MAX_LEN = 1518,
    parameter int MIN_LEN = 64
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [3:0] mii_rxd,
    input  logic       mii_rx_dv,
    input  logic       mii_rx_er,
    output logic [7:0] m_data,
    output logic       m_valid,
    output logic       m_last,
    output logic       m_err,
    output logic       frame_ok,
    output logic       frame_bad
);

`ifdef ETH_RX_MINLEN_CHECK_EN
    localparam bit MINLEN_EN = 1'b1;
`else
    localparam bit MINLEN_EN = 1'b0;
`endif

    localparam logic [10:0] MAX_L    = 11'(MAX_LEN);
    localparam logic [10:0] MIN_L    = 11'(MIN_LEN);
    // Four FCS bytes sit in the delay line, so the hold register only
    // carries payload once five bytes have arrived.
    localparam logic [10:0] HOLD_MIN = 11'd5;

    state_t      state;
    logic [31:0] crc;
    logic [31:0] crc_next;
    logic [10:0] count;
    logic        nib_odd;
    logic [3:0]  nib_lo;
    logic [31:0] dline;
    logic [7:0]  hold;
    logic        rx_err;
    logic        line_idle;
    logic        short_frame;
    logic        bad;

    crc32 #(
        .WIDTH(4)
    ) u_crc (
        .crc_in (crc),
        .data   (mii_rxd),
        .crc_out(crc_next)
    );

    assign short_frame = MINLEN_EN && (count < MIN_L);

    assign bad = (crc != CRC_RESIDUE) || rx_err || nib_odd
              || short_frame || (count < HOLD_MIN);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            crc       <= CRC_INIT;
            count     <= '0;
            nib_odd   <= 1'b0;
            nib_lo    <= '0;
            dline     <= '0;
            hold      <= '0;
            rx_err    <= 1'b0;
            line_idle <= 1'b0;
            m_data    <= '0;
            m_valid   <= 1'b0;
            m_last    <= 1'b0;
            m_err     <= 1'b0;
            frame_ok  <= 1'b0;
            frame_bad <= 1'b0;
        end else begin
            m_valid   <= 1'b0;
            m_last    <= 1'b0;
            m_err     <= 1'b0;
            frame_ok  <= 1'b0;
            frame_bad <= 1'b0;
            // A start is only honoured after the line was seen idle, so a
            // frame cut by reset is not picked up in its middle.
            line_idle <= !mii_rx_dv;
            unique case (state)
                IDLE: begin
                    if (mii_rx_dv) begin
                        if (line_idle && mii_rxd == PREAMBLE_NIB) begin
                            state <= PREAMBLE;
                        end else begin
                            state <= DROP;
                        end
                    end
                end
                PREAMBLE: begin
                    if (!mii_rx_dv) begin
                        state <= IDLE;
                    end else if (mii_rxd == SFD_NIB) begin
                        state   <= DATA;
                        crc     <= CRC_INIT;
                        count   <= '0;
                        nib_odd <= 1'b0;
                        rx_err  <= 1'b0;
                        dline   <= '0;
                        hold    <= '0;
                    end else if (mii_rxd != PREAMBLE_NIB) begin
                        state <= DROP;
                    end
                end
                DATA: begin
                    if (!mii_rx_dv) begin
                        state     <= IDLE;
                        frame_ok  <= !bad;
                        frame_bad <= bad;
                        if (count >= HOLD_MIN) begin
                            m_valid <= 1'b1;
                            m_data  <= hold;
                            m_last  <= 1'b1;
                            m_err   <= bad;
                        end
                    end else begin
                        crc     <= crc_next;
                        nib_odd <= !nib_odd;
                        if (mii_rx_er) begin
                            rx_err <= 1'b1;
                        end
                        if (!nib_odd) begin
                            nib_lo <= mii_rxd;
                        end else if (count == MAX_L) begin
                            // Oversize: close the frame on the held byte.
                            state     <= DROP;
                            m_valid   <= 1'b1;
                            m_data    <= hold;
                            m_last    <= 1'b1;
                            m_err     <= 1'b1;
                            frame_bad <= 1'b1;
                        end else begin
                            dline <= {dline[23:0], mii_rxd, nib_lo};
                            hold  <= dline[31:24];
                            if (count >= HOLD_MIN) begin
                                m_valid <= 1'b1;
                                m_data  <= hold;
                            end
                            if (count != 11'h7FF) begin
                                count <= count + 11'd1;
                            end
                        end
                    end
                end
                DROP: begin
                    if (!mii_rx_dv) begin
                        state <= IDLE;
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_eth_rx_fcs.sv
// Randomised self-checking bench for eth_rx_fcs with a frame-level model.
// Runs with MAX_LEN=64; honours ETH_RX_MINLEN_CHECK_EN when defined.
module tb_eth_rx_fcs;

    localparam int MAXL = 64;
    localparam int MINL = 64;
`ifdef ETH_RX_MINLEN_CHECK_EN
    localparam bit MIN_CHK = 1'b1;
`else
    localparam bit MIN_CHK = 1'b0;
`endif

    typedef struct packed {
        logic [7:0] d;
        logic       last;
        logic       err;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [3:0] mii_rxd = 4'h0;
    logic       mii_rx_dv = 1'b0;
    logic       mii_rx_er = 1'b0;
    logic [7:0] m_data;
    logic       m_valid;
    logic       m_last;
    logic       m_err;
    logic       frame_ok;
    logic       frame_bad;

    int vectors = 0;
    int miscompares = 0;
    int n_valid = 0;
    int n_last = 0;
    int n_err = 0;
    int n_ok = 0;
    int n_bad = 0;
    logic [7:0] last_data = 8'h00;

    logic [7:0] frm[$];
    exp_t       exp_q[$];
    bit         sq[$];

    eth_rx_fcs #(
        .MAX_LEN(MAXL),
        .MIN_LEN(MINL)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .mii_rxd  (mii_rxd),
        .mii_rx_dv(mii_rx_dv),
        .mii_rx_er(mii_rx_er),
        .m_data   (m_data),
        .m_valid  (m_valid),
        .m_last   (m_last),
        .m_err    (m_err),
        .frame_ok (frame_ok),
        .frame_bad(frame_bad)
    );

    always #5 clk = ~clk;

    // Standard CRC-32 of frm[0..n-1], final value inverted.
    function automatic logic [31:0] crc_of(input int n);
        logic [31:0] c;
        c = 32'hFFFFFFFF;
        for (int i = 0; i < n; i++) begin
            c = c ^ {24'h0, frm[i]};
            for (int b = 0; b < 8; b++) begin
                c = c[0] ? ((c >> 1) ^ 32'hEDB88320) : (c >> 1);
            end
        end
        return ~c;
    endfunction

    function automatic logic [3:0] nib(input int i, input logic [3:0] xn);
        logic [7:0] b;
        if (i >= 2 * frm.size()) return xn;
        b = frm[i / 2];
        return (i % 2 == 0) ? b[3:0] : b[7:4];
    endfunction

    task automatic chk(input string name, input int act, input int req);
        vectors++;
        if (act != req) begin
            miscompares++;
            $display("FAIL %s: got %0d, expected %0d", name, act, req);
        end
    endtask

    task automatic push_fcs();
        logic [31:0] c;
        c = crc_of(frm.size());
        frm.push_back(c[7:0]);
        frm.push_back(c[15:8]);
        frm.push_back(c[23:16]);
        frm.push_back(c[31:24]);
    endtask

    task automatic build_std();
        frm.delete();
        for (int i = 0; i < 9; i++) frm.push_back(8'h31 + 8'(i));
        push_fcs();
    endtask

    // Frame-level expectation: payload = all but the last four bytes.
    task automatic model(input bit odd, input bit er);
        int          nb;
        logic [31:0] c;
        logic [31:0] fcs;
        bit          isbad;
        exp_t        e;
        nb = frm.size();
        if (nb > MAXL) begin
            for (int i = 0; i < MAXL - 4; i++) begin
                e.d = frm[i];
                e.last = (i == MAXL - 5);
                e.err = (i == MAXL - 5);
                exp_q.push_back(e);
            end
            sq.push_back(1'b1);
        end else if (nb < 5) begin
            sq.push_back(1'b1);
        end else begin
            c = crc_of(nb - 4);
            fcs = {frm[nb-1], frm[nb-2], frm[nb-3], frm[nb-4]};
            isbad = (c != fcs) || er || odd || (MIN_CHK && nb < MINL);
            for (int i = 0; i < nb - 4; i++) begin
                e.d = frm[i];
                e.last = (i == nb - 5);
                e.err = (i == nb - 5) && isbad;
                exp_q.push_back(e);
            end
            sq.push_back(isbad);
        end
    endtask

    task automatic send(input int pre, input int er_idx, input bit odd,
                        input logic [3:0] xn, input int gap);
        int nn;
        nn = 2 * frm.size() + (odd ? 1 : 0);
        model(odd, er_idx >= 0 && er_idx < nn);
        for (int i = 0; i < pre; i++) begin
            @(negedge clk);
            mii_rx_dv = 1'b1;
            mii_rxd = 4'h5;
            mii_rx_er = 1'b0;
        end
        @(negedge clk);
        mii_rxd = 4'hD;
        for (int i = 0; i < nn; i++) begin
            @(negedge clk);
            mii_rxd = nib(i, xn);
            mii_rx_er = (i == er_idx);
        end
        for (int i = 0; i < gap; i++) begin
            @(negedge clk);
            mii_rx_dv = 1'b0;
            mii_rxd = 4'h0;
            mii_rx_er = 1'b0;
        end
    endtask

    task automatic settle();
        repeat (4) @(negedge clk);
        #2;
    endtask

    always begin
        exp_t e;
        bit   s;
        @(negedge clk);
        #1;
        if (!rst_n) begin
            vectors++;
            if ({m_valid, m_last, m_err, frame_ok, frame_bad} != 5'b0
                || m_data != 8'h00) begin
                miscompares++;
                $display("FAIL reset_state: got v/l/e/ok/bad=%b data=%h, expected 00000 data=00",
                         {m_valid, m_last, m_err, frame_ok, frame_bad}, m_data);
            end
        end else begin
            if (m_valid) begin
                vectors++;
                n_valid++;
                last_data = m_data;
                if (m_last) n_last++;
                if (m_err) n_err++;
                if (exp_q.size() == 0) begin
                    miscompares++;
                    $display("FAIL unexpected_byte: got %h last=%b err=%b, expected no output",
                             m_data, m_last, m_err);
                end else begin
                    e = exp_q.pop_front();
                    if (m_data != e.d || m_last != e.last || m_err != e.err) begin
                        miscompares++;
                        $display("FAIL payload_byte: got %h last=%b err=%b, expected %h last=%b err=%b",
                                 m_data, m_last, m_err, e.d, e.last, e.err);
                    end
                end
            end else if (m_last || m_err) begin
                vectors++;
                miscompares++;
                $display("FAIL strobe_qual: got last=%b err=%b without m_valid, expected 0", m_last, m_err);
            end
            if (m_last && !(frame_ok || frame_bad)) begin
                vectors++;
                miscompares++;
                $display("FAIL status_with_last: got no status pulse, expected ok or bad");
            end
            if (frame_ok || frame_bad) begin
                vectors++;
                if (frame_ok && frame_bad) begin
                    miscompares++;
                    $display("FAIL status_excl: got ok=1 bad=1, expected one");
                end else if (sq.size() == 0) begin
                    miscompares++;
                    $display("FAIL unexpected_status: got ok=%b bad=%b, expected none", frame_ok, frame_bad);
                end else begin
                    s = sq.pop_front();
                    if (frame_bad != s) begin
                        miscompares++;
                        $display("FAIL frame_status: got bad=%b, expected bad=%b", frame_bad, s);
                    end
                end
                if (frame_ok) n_ok++;
                else n_bad++;
            end
        end
    end

    initial begin
        int   v0, b0, o0, e0, l0;
        int   kind, plen, k;
        logic [31:0] c;

        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);

        // Pin the reference CRC to the well-known check value.
        frm.delete();
        for (int i = 0; i < 9; i++) frm.push_back(8'h31 + 8'(i));
        c = crc_of(9);
        chk("crc_check_value", int'(c == 32'hCBF43926), 1);

        // Good "123456789" frame.
        build_std();
        chk("fcs_byte0", int'(frm[9]), 8'h26);
        chk("fcs_byte3", int'(frm[12]), 8'hCB);
        v0 = n_valid; o0 = n_ok; e0 = n_err;
        send(15, -1, 1'b0, 4'h0, 2);
        settle();
        chk("std_bytes", n_valid - v0, 9);
        chk("std_last_data", int'(last_data), 8'h39);
        chk("std_ok", n_ok - o0, MIN_CHK ? 0 : 1);
        chk("std_err", n_err - e0, MIN_CHK ? 1 : 0);

        // FCS bit flipped.
        build_std();
        frm[11] = frm[11] ^ 8'h10;
        v0 = n_valid; b0 = n_bad;
        send(15, -1, 1'b0, 4'h0, 1);
        settle();
        chk("badfcs_bytes", n_valid - v0, 9);
        chk("badfcs_bad", n_bad - b0, 1);

        // rx_er during DATA with valid CRC.
        build_std();
        b0 = n_bad; e0 = n_err;
        send(15, 7, 1'b0, 4'h0, 1);
        settle();
        chk("rxer_bad", n_bad - b0, 1);
        chk("rxer_err", n_err - e0, 1);

        // Extra trailing nibble.
        build_std();
        e0 = n_err;
        send(15, -1, 1'b1, 4'h3, 1);
        settle();
        chk("align_err", n_err - e0, 1);

        // Oversize frame: 100 bytes.
        frm.delete();
        for (int i = 0; i < 100; i++) frm.push_back(8'($urandom));
        v0 = n_valid; b0 = n_bad; l0 = n_last;
        send(7, -1, 1'b0, 4'h0, 1);
        settle();
        chk("ovf_bytes", n_valid - v0, 60);
        chk("ovf_bad", n_bad - b0, 1);
        chk("ovf_last", n_last - l0, 1);

        // Runt frame: 3 bytes.
        frm.delete();
        for (int i = 0; i < 3; i++) frm.push_back(8'($urandom));
        v0 = n_valid; b0 = n_bad;
        send(3, -1, 1'b0, 4'h0, 1);
        settle();
        chk("runt_bytes", n_valid - v0, 0);
        chk("runt_bad", n_bad - b0, 1);

        // Reset in mid-payload, then a clean frame.
        frm.delete();
        for (int i = 0; i < 20; i++) frm.push_back(8'($urandom));
        v0 = n_valid; l0 = n_last;
        for (int i = 0; i < 7; i++) begin
            @(negedge clk);
            mii_rx_dv = 1'b1;
            mii_rxd = 4'h5;
        end
        @(negedge clk);
        mii_rxd = 4'hD;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            mii_rxd = nib(i, 4'h0);
            if (i == 6) rst_n = 1'b0;
            if (i == 8) rst_n = 1'b1;
        end
        @(negedge clk);
        mii_rx_dv = 1'b0;
        mii_rxd = 4'h0;
        settle();
        chk("rst_no_bytes", n_valid - v0, 0);
        chk("rst_no_last", n_last - l0, 0);
        build_std();
        l0 = n_last;
        send(15, -1, 1'b0, 4'h0, 1);
        settle();
        chk("post_rst_last", n_last - l0, 1);

        // Randomised back-to-back frames.
        for (int f = 0; f < 40; f++) begin
            kind = $urandom_range(0, 9);
            frm.delete();
            if (kind == 0) begin
                plen = $urandom_range(0, 4);
                for (int i = 0; i < plen; i++) frm.push_back(8'($urandom));
            end else begin
                plen = $urandom_range(1, 66);
                for (int i = 0; i < plen; i++) frm.push_back(8'($urandom));
                push_fcs();
                if (kind == 1) begin
                    k = $urandom_range(0, frm.size() - 1);
                    frm[k] = frm[k] ^ (8'h01 << $urandom_range(0, 7));
                end
            end
            send($urandom_range(1, 15),
                 (kind == 2) ? int'($urandom_range(0, 2 * frm.size() - 1)) : -1,
                 kind == 3, 4'($urandom), $urandom_range(1, 3));
        end

        settle();
        repeat (6) @(negedge clk);
        chk("data_drained", exp_q.size(), 0);
        chk("status_drained", sq.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
